bus_copier: RTL and testbench

- Bus initiator that copies a block of 32-bit words from a source address to a destination address over the SoC register bus.
- Drives the initiator side of the standard req/resp/fault peripheral protocol: addr, w_rb, acc, wdata and req out; rdata, resp and fault in.
- Sits beside the core as a second bus master, used for boot-time copy from flash to SRAM.
- Reports completion or error, with a cause code and faulting address, to software or to the reset controller's soc_fault inputs.

---
 rtl/bus_copier.sv | 276 +++++++++++++++++++++++++++
 tb/tb_bus_copier.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_copier.sv
// bus_copier: second bus master that copies a block of 32-bit words from a
// source address to a destination address over the req/resp/fault register
// bus, one read followed by one write per word. Reports done, or err with a
// cause code and the faulting bus address.
//
// Optional feature macro: BUS_COPIER_TIMEOUT_EN
//   defined   - an 8-bit wait counter aborts an access (cause 8'h03) when no
//               resp arrives within TIMEOUT cycles; TIMEOUT parameter exists.
//   undefined - the copier waits for resp indefinitely.
//
// Cause codes: 8'h01 read fault, 8'h02 write fault, 8'h03 timeout,
//              8'h04 misaligned cfg address.

`ifndef BUS_ACC_4B
`define BUS_ACC_4B 2'd2
`endif

module bus_copier #(
  parameter int unsigned XLEN          = 32,
  parameter int unsigned BUS_WIDTH     = 32,
  parameter int unsigned BUS_ACC_WIDTH = 2
`ifdef BUS_COPIER_TIMEOUT_EN
  , parameter int unsigned TIMEOUT     = 255
`endif
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [XLEN-1:0]          cfg_src,
  input  logic [XLEN-1:0]          cfg_dst,
  input  logic [15:0]              cfg_len,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [7:0]               err_cause,
  output logic [XLEN-1:0]          err_addr,
  output logic [XLEN-1:0]          addr,
  output logic                     w_rb,
  output logic [BUS_ACC_WIDTH-1:0] acc,
  output logic [BUS_WIDTH-1:0]     wdata,
  output logic                     req,
  input  logic [BUS_WIDTH-1:0]     rdata,
  input  logic                     resp,
  input  logic                     fault
);

  localparam int unsigned LEN_W = 16;
  localparam int unsigned CAUSE_W = 8;

  localparam logic [CAUSE_W-1:0] CAUSE_NONE     = 8'h00;
  localparam logic [CAUSE_W-1:0] CAUSE_RD_FAULT = 8'h01;
  localparam logic [CAUSE_W-1:0] CAUSE_WR_FAULT = 8'h02;
`ifdef BUS_COPIER_TIMEOUT_EN
  localparam logic [CAUSE_W-1:0] CAUSE_TIMEOUT  = 8'h03;
  localparam int unsigned        WAIT_W         = 8;
  localparam logic [WAIT_W-1:0]  WAIT_LAST      = WAIT_W'(TIMEOUT - 1);
`endif
  localparam logic [CAUSE_W-1:0] CAUSE_ALIGN    = 8'h04;

  localparam logic [XLEN-1:0] WORD_BYTES = XLEN'(4);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR_REQ  = 3'd3,
    WR_WAIT = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [XLEN-1:0]      src_q, src_d;
  logic [XLEN-1:0]      dst_q, dst_d;
  logic [LEN_W-1:0]     cnt_q, cnt_d;
  logic                 req_q, req_d;
  logic                 w_rb_q, w_rb_d;
  logic [XLEN-1:0]      addr_q, addr_d;
  logic [BUS_WIDTH-1:0] wdata_q, wdata_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic [CAUSE_W-1:0]   err_cause_q, err_cause_d;
  logic [XLEN-1:0]      err_addr_q, err_addr_d;
`ifdef BUS_COPIER_TIMEOUT_EN
  logic [WAIT_W-1:0]    wait_q, wait_d;
`endif

  // Next-state and registered-output computation for the copy sequencer.
  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    dst_d       = dst_q;
    cnt_d       = cnt_q;
    req_d       = 1'b0;
    w_rb_d      = w_rb_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    err_cause_d = err_cause_q;
    err_addr_d  = err_addr_q;
`ifdef BUS_COPIER_TIMEOUT_EN
    wait_d      = '0;
`endif

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (cfg_src[1:0] != 2'b00) begin
            err_d       = 1'b1;
            err_cause_d = CAUSE_ALIGN;
            err_addr_d  = cfg_src;
          end else if (cfg_dst[1:0] != 2'b00) begin
            err_d       = 1'b1;
            err_cause_d = CAUSE_ALIGN;
            err_addr_d  = cfg_dst;
          end else if (cfg_len == '0) begin
            done_d      = 1'b1;
            err_cause_d = CAUSE_NONE;
            err_addr_d  = '0;
          end else begin
            src_d       = cfg_src;
            dst_d       = cfg_dst;
            cnt_d       = cfg_len;
            err_cause_d = CAUSE_NONE;
            err_addr_d  = '0;
            busy_d      = 1'b1;
            state_d     = RD_REQ;
            req_d       = 1'b1;
            w_rb_d      = 1'b0;
            addr_d      = cfg_src;
          end
        end
      end

      RD_REQ: begin
        if (fault) begin
          state_d     = IDLE;
          busy_d      = 1'b0;
          err_d       = 1'b1;
          err_cause_d = CAUSE_RD_FAULT;
          err_addr_d  = src_q;
        end else begin
          state_d = RD_WAIT;
        end
      end

      RD_WAIT: begin
        if (resp) begin
          wdata_d = rdata;
          state_d = WR_REQ;
          req_d   = 1'b1;
          w_rb_d  = 1'b1;
          addr_d  = dst_q;
        end else begin
`ifdef BUS_COPIER_TIMEOUT_EN
          if (wait_q == WAIT_LAST) begin
            state_d     = IDLE;
            busy_d      = 1'b0;
            err_d       = 1'b1;
            err_cause_d = CAUSE_TIMEOUT;
            err_addr_d  = src_q;
          end else begin
            wait_d = wait_q + WAIT_W'(1);
          end
`endif
        end
      end

      WR_REQ: begin
        if (fault) begin
          state_d     = IDLE;
          busy_d      = 1'b0;
          err_d       = 1'b1;
          err_cause_d = CAUSE_WR_FAULT;
          err_addr_d  = dst_q;
        end else begin
          state_d = WR_WAIT;
        end
      end

      WR_WAIT: begin
        if (resp) begin
          src_d = src_q + WORD_BYTES;
          dst_d = dst_q + WORD_BYTES;
          cnt_d = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = RD_REQ;
            req_d   = 1'b1;
            w_rb_d  = 1'b0;
            addr_d  = src_q + WORD_BYTES;
          end
        end else begin
`ifdef BUS_COPIER_TIMEOUT_EN
          if (wait_q == WAIT_LAST) begin
            state_d     = IDLE;
            busy_d      = 1'b0;
            err_d       = 1'b1;
            err_cause_d = CAUSE_TIMEOUT;
            err_addr_d  = dst_q;
          end else begin
            wait_d = wait_q + WAIT_W'(1);
          end
`endif
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      src_q       <= '0;
      dst_q       <= '0;
      cnt_q       <= '0;
      req_q       <= 1'b0;
      w_rb_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_cause_q <= '0;
      err_addr_q  <= '0;
`ifdef BUS_COPIER_TIMEOUT_EN
      wait_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      w_rb_q      <= w_rb_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      err_cause_q <= err_cause_d;
      err_addr_q  <= err_addr_d;
`ifdef BUS_COPIER_TIMEOUT_EN
      wait_q      <= wait_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign err_cause = err_cause_q;
  assign err_addr  = err_addr_q;
  assign addr      = addr_q;
  assign w_rb      = w_rb_q;
  assign wdata     = wdata_q;
  assign req       = req_q;
  assign acc       = BUS_ACC_WIDTH'(`BUS_ACC_4B);

`ifndef SYNTHESIS
  // Completion flags are exclusive and busy has already dropped when they fire.
  a_done_err_excl : assert property (@(posedge clk) disable iff (!rst_n) !(done_q && err_q));
  a_busy_on_end   : assert property (@(posedge clk) disable iff (!rst_n) !(busy_q && (done_q || err_q)));
  a_req_in_busy   : assert property (@(posedge clk) disable iff (!rst_n) req_q |-> busy_q);
`endif

endmodule

// File: tb/tb_bus_copier.sv
// Self-checking bench for bus_copier: a negedge-driven bus responder backed by
// a synthetic source memory, directed scenarios plus randomized transfers, all
// compared against a transaction-level model of the expected bus traffic.
module tb_bus_copier;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] cfg_src = '0;
  logic [31:0] cfg_dst = '0;
  logic [15:0] cfg_len = '0;
  logic        busy, done, err;
  logic [7:0]  err_cause;
  logic [31:0] err_addr, addr, wdata;
  logic        w_rb, req;
  logic [1:0]  acc;
  logic [31:0] rdata = '0;
  logic        resp = 1'b0;
  logic        fault = 1'b0;

  always #5 clk = ~clk;

  bus_copier #(
    .XLEN(32), .BUS_WIDTH(32), .BUS_ACC_WIDTH(2)
`ifdef BUS_COPIER_TIMEOUT_EN
    , .TIMEOUT(4)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cfg_src(cfg_src), .cfg_dst(cfg_dst), .cfg_len(cfg_len),
    .busy(busy), .done(done), .err(err), .err_cause(err_cause), .err_addr(err_addr),
    .addr(addr), .w_rb(w_rb), .acc(acc), .wdata(wdata), .req(req),
    .rdata(rdata), .resp(resp), .fault(fault)
  );

  int n_vec = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- responder ----------------
  int          lat = 1;
  int          fault_rd_n = 0;
  int          fault_wr_n = 0;
  bit          no_rd_resp = 1'b0;
  bit          spur_en = 1'b0;
  logic [31:0] seed = 32'h1234_5678;
  int          pend = 0;
  logic [31:0] pend_data = '0;
  int          rd_seen = 0;
  int          wr_seen = 0;

  function automatic logic [31:0] src_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ seed ^ 32'h5A5A_0000;
  endfunction

  always @(negedge clk) begin
    resp  = 1'b0;
    fault = 1'b0;
    if (!busy) begin
      rd_seen = 0;
      wr_seen = 0;
    end
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        resp  = 1'b1;
        rdata = pend_data;
      end
    end else if (spur_en && !busy && !req && ($urandom_range(3) == 0)) begin
      resp  = 1'b1;
      rdata = $urandom;
    end
    if (req) begin
      if (!w_rb) begin
        rd_seen++;
        if (rd_seen == fault_rd_n) fault = 1'b1;
        else if (!no_rd_resp) begin
          pend      = lat;
          pend_data = src_word(addr);
        end
      end else begin
        wr_seen++;
        if (wr_seen == fault_wr_n) fault = 1'b1;
        else pend = lat;
      end
    end
  end

  // ---------------- transfer runner ----------------
  typedef struct {
    bit          w;
    logic [31:0] a;
    logic [31:0] d;
  } txn_t;

  txn_t        log_q[$];
  int          done_cyc, err_cyc, busy_cnt, n_done, n_err, viol;
  bit          timed_out;
  logic [7:0]  c1_cause;

  // Called at a negedge; start is sampled at the following posedge (cycle 0).
  task automatic run_copy(input logic [31:0] src, input logic [31:0] dst,
                          input logic [15:0] len, input int budget, input int poke_at);
    int cyc;
    log_q.delete();
    done_cyc = 0; err_cyc = 0; busy_cnt = 0; n_done = 0; n_err = 0; viol = 0;
    timed_out = 1'b1; c1_cause = 8'hxx;
    cfg_src = src; cfg_dst = dst; cfg_len = len; start = 1'b1;
    cyc = 0;
    while (cyc < budget) begin
      @(negedge clk);
      cyc++;
      start = (cyc == poke_at);
      if (cyc == poke_at) begin
        cfg_src = 32'h0000_5000; cfg_dst = 32'h0000_6000; cfg_len = 16'd7;
      end
      if (cyc == 1) c1_cause = err_cause;
      if (req) log_q.push_back('{w_rb, addr, wdata});
      if (busy) busy_cnt++;
      if (done) begin n_done++; if (done_cyc == 0) done_cyc = cyc; end
      if (err)  begin n_err++;  if (err_cyc == 0)  err_cyc = cyc;  end
      if (done && err) viol++;
      if (busy && (done || err)) viol++;
      if ((done_cyc != 0 && cyc >= done_cyc + 3) || (err_cyc != 0 && cyc >= err_cyc + 3)) begin
        timed_out = 1'b0;
        break;
      end
    end
    start = 1'b0;
  endtask

  // Transaction-level model: expected read/write list and outcome.
  task automatic check_xfer(input string tag, input logic [31:0] src, input logic [31:0] dst,
                            input logic [15:0] len, input int frd, input int fwr, input int l);
    txn_t        q[$];
    bit          ex_err;
    logic [7:0]  ex_cause;
    logic [31:0] ex_addr;
    int          n;
    ex_err = 1'b0; ex_cause = 8'h00; ex_addr = 32'h0;
    if (src[1:0] != 2'b00) begin
      ex_err = 1'b1; ex_cause = 8'h04; ex_addr = src;
    end else if (dst[1:0] != 2'b00) begin
      ex_err = 1'b1; ex_cause = 8'h04; ex_addr = dst;
    end else begin
      for (int i = 0; i < int'(len); i++) begin
        logic [31:0] ra, wa;
        ra = src + 32'(4 * i);
        wa = dst + 32'(4 * i);
        q.push_back('{1'b0, ra, 32'h0});
        if (i + 1 == frd) begin ex_err = 1'b1; ex_cause = 8'h01; ex_addr = ra; break; end
        q.push_back('{1'b1, wa, src_word(ra)});
        if (i + 1 == fwr) begin ex_err = 1'b1; ex_cause = 8'h02; ex_addr = wa; break; end
      end
    end
    check({tag, " timeout"}, 32'(timed_out), 32'd0);
    check({tag, " nreq"}, 32'(log_q.size()), 32'(q.size()));
    n = (log_q.size() < q.size()) ? log_q.size() : q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s req%0d w_rb", tag, i), 32'(log_q[i].w), 32'(q[i].w));
      check($sformatf("%s req%0d addr", tag, i), log_q[i].a, q[i].a);
      if (q[i].w) check($sformatf("%s req%0d wdata", tag, i), log_q[i].d, q[i].d);
    end
    check({tag, " done_cnt"}, 32'(n_done), ex_err ? 32'd0 : 32'd1);
    check({tag, " err_cnt"}, 32'(n_err), ex_err ? 32'd1 : 32'd0);
    check({tag, " err_cause"}, 32'(err_cause), 32'(ex_cause));
    check({tag, " err_addr"}, err_addr, ex_addr);
    check({tag, " overlap"}, 32'(viol), 32'd0);
    if (!ex_err) check({tag, " done_cyc"}, 32'(done_cyc), 32'(1 + int'(len) * (2 + 2 * l)));
    else if (ex_cause == 8'h04) check({tag, " err_cyc"}, 32'(err_cyc), 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [31:0] s, d;
    logic [15:0] ln;
    int          frd, fwr, l, nbad;
    bit          found;

    // reset values
    repeat (3) @(negedge clk);
    check("rst req", 32'(req), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst err", 32'(err), 32'd0);
    check("rst err_cause", 32'(err_cause), 32'd0);
    check("rst err_addr", err_addr, 32'd0);
    check("rst addr", addr, 32'd0);
    check("rst w_rb", 32'(w_rb), 32'd0);
    check("rst wdata", wdata, 32'd0);
    check("rst acc", 32'(acc), 32'd2);
    rst_n = 1'b1;
    @(negedge clk);

    // basic three-word copy, 1-cycle responder
    lat = 1;
    run_copy(32'h1000, 32'h2000, 16'd3, 200, 0);
    check_xfer("basic", 32'h1000, 32'h2000, 16'd3, 0, 0, 1);
    check("basic busy_cycles", 32'(busy_cnt), 32'd12);

    // zero length and misaligned destination
    run_copy(32'h1000, 32'h2000, 16'd0, 50, 0);
    check_xfer("len0", 32'h1000, 32'h2000, 16'd0, 0, 0, 1);
    run_copy(32'h1000, 32'h2002, 16'd3, 50, 0);
    check_xfer("misalign", 32'h1000, 32'h2002, 16'd3, 0, 0, 1);

    // read fault on second read, then a fresh start clears the cause
    fault_rd_n = 2;
    run_copy(32'h1000, 32'h2000, 16'd3, 200, 0);
    check_xfer("rdfault", 32'h1000, 32'h2000, 16'd3, 2, 0, 1);
    fault_rd_n = 0;
    run_copy(32'h1000, 32'h2000, 16'd2, 200, 0);
    check("restart clears cause", 32'(c1_cause), 32'd0);
    check_xfer("after_rdfault", 32'h1000, 32'h2000, 16'd2, 0, 0, 1);

    // write fault on first write
    fault_wr_n = 1;
    run_copy(32'h1000, 32'h2000, 16'd3, 200, 0);
    check_xfer("wrfault", 32'h1000, 32'h2000, 16'd3, 0, 1, 1);
    fault_wr_n = 0;

    // source address wrap
    run_copy(32'hFFFF_FFFC, 32'h3000, 16'd2, 200, 0);
    check_xfer("wrap", 32'hFFFF_FFFC, 32'h3000, 16'd2, 0, 0, 1);
    if (log_q.size() > 2) check("wrap 2nd read addr", log_q[2].a, 32'h0);
    else check("wrap 2nd read present", 32'(log_q.size()), 32'd3);

    // read that never gets a response
    no_rd_resp = 1'b1;
`ifdef BUS_COPIER_TIMEOUT_EN
    run_copy(32'h1000, 32'h2000, 16'd2, 100, 0);
    check("tmo err_cyc", 32'(err_cyc), 32'd6);
    check("tmo err_cause", 32'(err_cause), 32'h03);
    check("tmo err_addr", err_addr, 32'h1000);
    check("tmo nreq", 32'(log_q.size()), 32'd1);
`else
    run_copy(32'h1000, 32'h2000, 16'd2, 200, 0);
    check("hang busy", 32'(busy), 32'd1);
    check("hang done_err", 32'(n_done + n_err), 32'd0);
    check("hang nreq", 32'(log_q.size()), 32'd1);
`endif
    no_rd_resp = 1'b0;
    do_reset();
    @(negedge clk);

    // reset during WR_WAIT with resp arriving afterwards
    lat = 2;
    found = 1'b0;
    cfg_src = 32'h1000; cfg_dst = 32'h2000; cfg_len = 16'd3; start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (req && w_rb) begin found = 1'b1; break; end
    end
    check("rstmid found write", 32'(found), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rstmid req", 32'(req), 32'd0);
    check("rstmid busy", 32'(busy), 32'd0);
    nbad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (req || done || err || busy) nbad++;
    end
    check("rstmid quiet", 32'(nbad), 32'd0);

    // start pulses while busy are ignored
    lat = 1;
    run_copy(32'h1000, 32'h2000, 16'd3, 200, 5);
    check_xfer("busy_start", 32'h1000, 32'h2000, 16'd3, 0, 0, 1);

    // randomized transfers
    for (int it = 0; it < 30; it++) begin
      seed = $urandom;
      s = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(3) == 0) s = 32'hFFFF_FFF0 | 32'($urandom_range(3) * 4);
      d = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(9) == 0) s[1:0] = 2'($urandom_range(1, 3));
      if ($urandom_range(9) == 0) d[1:0] = 2'($urandom_range(1, 3));
      ln = 16'($urandom_range(6));
      l = $urandom_range(1, 3);
      frd = 0; fwr = 0;
      if (ln != 0 && $urandom_range(4) == 0) frd = $urandom_range(1, int'(ln));
      else if (ln != 0 && $urandom_range(4) == 0) fwr = $urandom_range(1, int'(ln));
      lat = l; fault_rd_n = frd; fault_wr_n = fwr;
      spur_en = ($urandom_range(1) == 1);
      run_copy(s, d, ln, 400, 0);
      check_xfer($sformatf("rnd%0d", it), s, d, ln, frd, fwr, l);
      fault_rd_n = 0; fault_wr_n = 0; spur_en = 1'b0;
      repeat (2) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
